wb_syscall_unit: RTL and testbench

Parametrised writeback stage for the pipelined MIPS core: selects register-file write data and enable from the stage control word, and services `syscall` instructions in hardware. Print requests (`$v0 = 1`) are buffered in a display FIFO drained by a valid/ready display port. Exit requests (`$v0 = 10`) drive a halt state machine that drains the FIFO, freezes retirement, and waits for an external resume. Replaces clock gating with an explicit stall/halt interface to the upstream pipeline.

---
 rtl/wb_syscall_unit.sv | 109 ++++++++++
 tb/tb_wb_syscall_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_syscall_unit.sv
// Writeback stage with hardware syscall service: register-file write mux, display FIFO for print
// syscalls, and a run/halt state machine for exit. Define WB_RETIRE_CNT_EN to enable the retire counter.
module wb_syscall_unit #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PRINT_CODE = 1,
    parameter int EXIT_CODE  = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [31:0]      in_signal,
    input  logic [WIDTH-1:0] in_d,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_v0,
    input  logic [WIDTH-1:0] in_a0,
    output logic [WIDTH-1:0] out_data,
    output logic             out_we,
    output logic             out_stall,
    output logic             halted,
    input  logic             resume,
    output logic             disp_valid,
    output logic [WIDTH-1:0] disp_data,
    input  logic             disp_ready,
    output logic             fifo_full,
    output logic [31:0]      retire_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;

    logic reg_write, mem_to_reg, jal, syscall;
    logic is_print, is_exit, accept, push, pop, empty;
    logic unused_signal_bits;

    assign reg_write  = in_signal[7];
    assign mem_to_reg = in_signal[3];
    assign jal        = in_signal[13];
    assign syscall    = in_signal[15];
    assign unused_signal_bits = ^{in_signal[31:16], in_signal[14], in_signal[12:8],
                                  in_signal[6:4], in_signal[2:0]};

    assign is_print = in_valid & syscall & (in_v0 == WIDTH'(PRINT_CODE));
    assign is_exit  = in_valid & syscall & (in_v0 == WIDTH'(EXIT_CODE));

    // Full is judged on the registered pointers only, so a same-cycle pop never unblocks a push.
    assign empty     = (wr_ptr == rd_ptr);
    assign fifo_full = ((wr_ptr - rd_ptr) == PTR_FULL);
    assign out_stall = (state != RUN) | (is_print & fifo_full);
    assign accept    = in_valid & ~out_stall;
    assign out_we    = accept & reg_write;
    assign out_data  = jal ? in_pc : (mem_to_reg ? in_d : in_r);

    assign push       = accept & is_print;
    assign pop        = disp_valid & disp_ready;
    assign disp_valid = ~empty;
    assign disp_data  = mem[rd_ptr[AW-1:0]];
    assign rd_next    = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign halted     = (state == HALTED);

    // NOTE: storage has no reset; emptiness comes from the pointers, so stale words are never shown.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_a0;
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            case (state)
                RUN:       if (accept & is_exit) state <= HALT_PEND;
                // No pushes happen here, so comparing against the post-pop read pointer
                // catches the FIFO going empty this very cycle.
                HALT_PEND: if (wr_ptr == rd_next) state <= HALTED;
                HALTED:    if (resume) state <= RUN;
                default:   state <= RUN;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) retire_cnt <= '0;
        else if (accept) retire_cnt <= retire_cnt + 32'd1;
    end
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_syscall_unit.sv
// Self-checking bench for wb_syscall_unit: directed scenarios plus randomized traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_wb_syscall_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] SIG_RTYPE = 32'h0000_0080;
    localparam logic [31:0] SIG_LOAD  = 32'h0000_0088;
    localparam logic [31:0] SIG_JAL   = 32'h0000_2080;
    localparam logic [31:0] SIG_STORE = 32'h0000_0000;
    localparam logic [31:0] SIG_SYS   = 32'h0000_8000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_signal = '0, in_d = '0, in_r = '0, in_v0 = '0, in_a0 = '0;
    logic [31:0] out_data, disp_data, retire_cnt;
    logic        out_we, out_stall, halted, disp_valid, fifo_full;
    logic        resume = 1'b0;
    logic        disp_ready = 1'b0;

    wb_syscall_unit #(.WIDTH(32), .FIFO_DEPTH(DEPTH), .PRINT_CODE(1), .EXIT_CODE(10)) dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_pc(in_pc), .in_signal(in_signal),
        .in_d(in_d), .in_r(in_r), .in_v0(in_v0), .in_a0(in_a0), .out_data(out_data),
        .out_we(out_we), .out_stall(out_stall), .halted(halted), .resume(resume),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .fifo_full(fifo_full), .retire_cnt(retire_cnt)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the display queue, a run/pending/halted mode and a retire tally.
    logic [31:0] m_fifo[$];
    int          m_mode = 0;   // 0 running, 1 waiting for drain, 2 halted
    logic [31:0] m_cnt = '0;
    logic        last_stalled = 1'b0;

    function automatic void model_reset();
        m_fifo.delete();
        m_mode = 0;
        m_cnt = '0;
        last_stalled = 1'b0;
    endfunction

    // Drive one cycle (called just after a falling edge), check outputs, advance the model.
    task automatic step(input logic v, input logic [31:0] sig, input logic [31:0] v0,
                        input logic [31:0] a0, input logic [31:0] d, input logic [31:0] r,
                        input logic [31:0] pc, input logic rdy, input logic res);
        bit          p, e, stall, acc, pop;
        logic [31:0] exp_data;
        in_valid = v; in_signal = sig; in_v0 = v0; in_a0 = a0;
        in_d = d; in_r = r; in_pc = pc; disp_ready = rdy; resume = res;
        #1;
        p = v && sig[15] && (v0 == 32'd1);
        e = v && sig[15] && (v0 == 32'd10);
        stall = (m_mode != 0) || (p && m_fifo.size() == DEPTH);
        acc = v && !stall;
        if (sig[13]) exp_data = pc;
        else if (sig[3]) exp_data = d;
        else exp_data = r;
        check("out_data", out_data, exp_data);
        check("out_we", out_we, acc && sig[7]);
        check("out_stall", out_stall, stall);
        check("disp_valid", disp_valid, m_fifo.size() != 0);
        check("fifo_full", fifo_full, m_fifo.size() == DEPTH);
        check("halted", halted, m_mode == 2);
        check("retire_cnt", retire_cnt, m_cnt);
        if (m_fifo.size() != 0) check("disp_data", disp_data, m_fifo[0]);
        last_stalled = v && stall;
        @(posedge Clock);
        pop = (m_fifo.size() != 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (acc && p) m_fifo.push_back(a0);
        if (m_mode == 0 && acc && e) m_mode = 1;
        else if (m_mode == 1 && m_fifo.size() == 0) m_mode = 2;
        else if (m_mode == 2 && res) m_mode = 0;
`ifdef WB_RETIRE_CNT_EN
        if (acc) m_cnt = m_cnt + 32'd1;
`endif
        @(negedge Clock);
    endtask

    task automatic idle(input logic rdy, input logic res);
        step(1'b0, SIG_STORE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, rdy, res);
    endtask

    task automatic print(input logic [31:0] val, input logic rdy);
        step(1'b1, SIG_SYS, 32'd1, val, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        model_reset();
        Reset = 1'b0;
    endtask

    logic        r_v, r_rdy, r_res;
    logic [31:0] r_sig, r_v0, r_a0, r_d, r_r, r_pc;

    initial begin
        model_reset();
        @(negedge Clock);
        #1;
        check("reset_disp_valid", disp_valid, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_fifo_full", fifo_full, 1'b0);
        check("reset_retire_cnt", retire_cnt, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // Data mux for R-type, load and JAL, plus a non-writing instruction.
        step(1'b1, SIG_RTYPE, 32'd0, 32'd0, 32'h22, 32'h11, 32'h400008, 1'b0, 1'b0);
        step(1'b1, SIG_LOAD,  32'd0, 32'd0, 32'h22, 32'h11, 32'h400008, 1'b0, 1'b0);
        step(1'b1, SIG_JAL,   32'd0, 32'd0, 32'h22, 32'h11, 32'h400008, 1'b0, 1'b0);
        step(1'b1, SIG_STORE, 32'd0, 32'd0, 32'h22, 32'h11, 32'h400008, 1'b0, 1'b0);

        // Fill the FIFO, stall a fifth print three cycles, then drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) print(32'(i), 1'b0);
        check("full_after_4", fifo_full, 1'b1);
        print(32'd5, 1'b0);
        print(32'd5, 1'b0);
        print(32'd5, 1'b1);
        print(32'd5, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, SIG_RTYPE, 32'd0, 32'd0, 32'd0, 32'(i), 32'd0, 1'b1, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        check("retire_10", retire_cnt, 32'd10);
`else
        check("retire_tied", retire_cnt, 32'd0);
`endif
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
        check("drained", disp_valid, 1'b0);

        // Exit with empty FIFO: halted two cycles later, then writes are blocked.
        step(1'b1, SIG_SYS, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("halted_n2", halted, 1'b1);
        step(1'b1, SIG_RTYPE, 32'd0, 32'd0, 32'd0, 32'h33, 32'd0, 1'b1, 1'b0);
        step(1'b1, SIG_RTYPE, 32'd0, 32'd0, 32'd0, 32'h33, 32'd0, 1'b1, 1'b1);
        check("resumed", halted, 1'b0);

        // Two prints then exit with the consumer ready; resume while pending is ignored.
        print(32'hA1, 1'b1);
        print(32'hA2, 1'b1);
        step(1'b1, SIG_SYS, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("halted_after_drain", halted, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        check("resume_run", halted, 1'b0);

        // Reset while three entries wait.
        for (int i = 0; i < 3; i++) print(32'h50 + 32'(i), 1'b0);
        #2 Reset = 1'b1;
        #1;
        check("mid_reset_disp_valid", disp_valid, 1'b0);
        check("mid_reset_halted", halted, 1'b0);
        check("mid_reset_retire_cnt", retire_cnt, 32'd0);
        check("mid_reset_full", fifo_full, 1'b0);
        @(negedge Clock);
        model_reset();
        Reset = 1'b0;

        // Randomized traffic; a stalled instruction is held stable until accepted.
        for (int n = 0; n < 3000; n++) begin
            if (!last_stalled) begin
                r_v = ($urandom_range(0, 3) != 0);
                r_sig = $urandom;
                r_sig[15] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: r_v0 = 32'd1;
                    4:          r_v0 = 32'd10;
                    5:          r_v0 = 32'd5;
                    default:    r_v0 = $urandom;
                endcase
                r_a0 = $urandom; r_d = $urandom; r_r = $urandom; r_pc = $urandom;
            end
            r_rdy = ($urandom_range(0, 2) != 0);
            r_res = ($urandom_range(0, 4) == 0);
            step(r_v, r_sig, r_v0, r_a0, r_d, r_r, r_pc, r_rdy, r_res);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
